wavetable_oscillator: RTL and testbench
=======================================

# wavetable_oscillator

- Phase-accumulator oscillator that sits directly upstream of the wavetable ROM stage.
- On each sample strobe it:
  - advances a PHASE_W-bit phase accumulator;
  - derives the table index, band and fractional phase;
  - drives the ROM address inputs and collects the registered ROM output;
  - emits one signed sample, linearly interpolated between adjacent table entries when compiled in.
- Its output feeds the voice mixer/DAC path.

## Interface
- N_LUT, 10, table address bits; table length 2^N_LUT
- DATA_W, 24, sample width (signed)
- NUM_WAVES, 4, number of waveforms
- NUM_BANDS, 22, band-limited tables per waveform
- PHASE_W, 32, accumulator width; must satisfy PHASE_W ≥ N_LUT+FRAC_W
- FRAC_W, 8, fractional bits used for interpolation
- BAND_SHIFT, 26, band = min(phase_inc >> BAND_SHIFT, NUM_BANDS-1)
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sample_tick  in  1  one-cycle strobe at sample rate Fs
- sync  in  1  hard sync; only meaningful together with an accepted sample_tick
- phase_inc  in  PHASE_W  unsigned per-sample phase increment
- wave_sel  in  $clog2(NUM_WAVES)  requested waveform
- waveform_select  out  $clog2(NUM_WAVES)  registered, to ROM stage
- phase_idx  out  N_LUT  registered table index, to ROM stage
- band  out  $clog2(NUM_BANDS-1)+1  registered band, to ROM stage
- lut_data  in  DATA_W  signed ROM output; valid one cycle after phase_idx/band/waveform_select are presented
- sample  out  DATA_W  signed output sample
- sample_valid  out  1  one-cycle pulse when sample updates
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  sticky; set when a tick is dropped; cleared only by reset

## Operation
- FSM states: IDLE, ADDR0, CAP0, CAP1. CAP1 exists only with interpolation compiled in.
- IDLE with sample_tick=1: the tick is accepted and the following are latched:
  - waveform_select <= wave_sel.
  - band <= min(phase_inc >> BAND_SHIFT, NUM_BANDS-1).
  - phase_idx <= acc[PHASE_W-1 -: N_LUT].
  - frac <= acc[PHASE_W-N_LUT-1 -: FRAC_W].
  - acc <= acc + phase_inc, modulo 2^PHASE_W.
  - Next state ADDR0.
- sync=1 on an accepted tick: the current acc is treated as 0, so phase_idx=0 and frac=0; acc <= phase_inc.
- ADDR0: the ROM samples its address at the end of this cycle. With interpolation, phase_idx <= phase_idx+1, wrapping modulo 2^N_LUT (1023→0, same table). Next state CAP0.
- CAP0:
  - Without interpolation: sample <= lut_data, sample_valid <= 1, next state IDLE.
  - With interpolation: s0 <= lut_data, next state CAP1.
- CAP1: sample <= s0 + ((lut_data − s0) × frac) >>> FRAC_W, sample_valid <= 1, next state IDLE.
  - The difference is computed at DATA_W+1 bits signed; frac is zero-extended.
  - The shift is arithmetic, i.e. floor rounding.
  - The result always lies between s0 and s1, so truncation to DATA_W never overflows.
- Tick arriving while busy=1: the tick is dropped, overrun <= 1, and the in-flight sample completes unaffected.
- phase_inc, wave_sel and sync are sampled only on an accepted tick; changes at other times have no effect.
- Band: the sine waveform ignores band downstream, but band is still driven per the formula above.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, acc=0, phase_idx=0, band=0, waveform_select=0, s0=0, frac=0, sample=0, sample_valid=0, busy=0, overrun=0.
- Reset mid-operation aborts the sample; no sample_valid is produced for it.
- With the tick accepted at edge E0, the address is visible in the cycle after E0.
- Latency, interpolation on: sample_valid is high in the cycle following E3, i.e. 3 cycles after the accepting edge.
- Latency, interpolation off: sample_valid is high in the cycle following E2, i.e. 2 cycles.
- sample_valid is exactly one cycle wide.
- sample holds its value until the next valid.
- busy is high from the cycle after E0 up to and including the final capture state.
- A tick in the same cycle that sample_valid is high is accepted, because the FSM is already in IDLE.
- Minimum tick spacing: 4 cycles with interpolation, 3 without.

## Configuration
- Macro: WAVETABLE_OSC_INTERP_EN.
- Defined: two ROM reads per sample (idx, idx+1) with linear interpolation by frac; latency 3.
- Undefined:
  - CAP1 and s0 are removed and frac is unused.
  - phase_idx is not incremented in ADDR0.
  - Output is nearest-lower table entry; latency 2.

## Test plan
- Reset/basic:
  - Stimulus: hold rst_n=0 for 3 cycles, then release; phase_inc=0x0100_0000; ticks every 8 cycles.
  - Required: all outputs 0 after reset; phase_idx sequence 0,4,8,…; band=0.
- Wrap:
  - Stimulus: acc preloaded via ticks so that idx=1023; interpolation on; ROM model returns entry 1023=1000, entry 0=2000; frac=0x80.
  - Required: second address 0 with the same band/waveform; sample=1500.
- Interpolation sign:
  - Stimulus: s0=100, s1=−100, frac=0x01.
  - Required: sample = 100 + floor(−200/256) = 99.
- Band clamp:
  - Stimulus: phase_inc=0xFFFF_FFFF.
  - Required: band=21; phase_inc=0x0400_0000 gives band=1.
- Overrun/sync:
  - Stimulus: tick on the cycle after an accepted tick.
  - Required: overrun=1 and exactly one sample_valid.
  - Stimulus: tick with sync=1.
  - Required: phase_idx=0 and acc=phase_inc.
- Reset mid-op:
  - Stimulus: rst_n=0 during CAP0.
  - Required: no sample_valid; busy=0 on the next cycle.

Source files
------------

// File: rtl/wavetable_oscillator.sv
// Phase-accumulator oscillator feeding the wavetable ROM stage.
// Ports: clk, rst_n (sync, active-low), sample_tick, sync, phase_inc,
//   wave_sel in; waveform_select/phase_idx/band out to ROM, lut_data
//   back from ROM; sample, sample_valid, busy, overrun out.
//   Optional linear interpolation: define WAVETABLE_OSC_INTERP_EN.
module wavetable_oscillator #(
  parameter int N_LUT      = 10,
  parameter int DATA_W     = 24,
  parameter int NUM_WAVES  = 4,
  parameter int NUM_BANDS  = 22,
  parameter int PHASE_W    = 32,
  parameter int FRAC_W     = 8,
  parameter int BAND_SHIFT = 26
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                sample_tick,
  input  logic                                sync,
  input  logic [PHASE_W-1:0]                  phase_inc,
  input  logic [$clog2(NUM_WAVES)-1:0]        wave_sel,
  output logic [$clog2(NUM_WAVES)-1:0]        waveform_select,
  output logic [N_LUT-1:0]                    phase_idx,
  output logic [$clog2(NUM_BANDS-1):0]        band,
  input  logic signed [DATA_W-1:0]            lut_data,
  output logic signed [DATA_W-1:0]            sample,
  output logic                                sample_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int BAND_W = $clog2(NUM_BANDS-1) + 1;
  localparam logic [PHASE_W-1:0] BAND_MAX = PHASE_W'(NUM_BANDS-1);

`ifdef WAVETABLE_OSC_INTERP_EN
  typedef enum logic [1:0] {IDLE, ADDR0, CAP0, CAP1} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR0, CAP0} state_t;
`endif

  state_t state, state_n;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] base;
  logic [PHASE_W-1:0] band_shr;
  logic [BAND_W-1:0]  band_nx;
  logic               accept;

  // Hard sync restarts the cycle: the current phase is taken as zero.
  assign base     = sync ? '0 : acc;
  assign band_shr = phase_inc >> BAND_SHIFT;
  assign band_nx  = (band_shr > BAND_MAX) ? BAND_W'(NUM_BANDS-1)
                                          : band_shr[BAND_W-1:0];

`ifdef WAVETABLE_OSC_INTERP_EN
  logic [FRAC_W-1:0]              frac;
  logic signed [DATA_W-1:0]       s0;
  logic signed [DATA_W:0]         diff;
  logic signed [DATA_W+FRAC_W+1:0] prod;
  logic signed [DATA_W-1:0]       interp;

  // s1 - s0 needs one extra bit; frac is treated as unsigned.
  assign diff = {lut_data[DATA_W-1], lut_data} - {s0[DATA_W-1], s0};
  assign prod = $signed({{(FRAC_W+1){diff[DATA_W]}}, diff})
              * $signed({{(DATA_W+1){1'b0}}, frac});
  // Result lies between s0 and s1, so dropping upper bits is safe.
  assign interp = DATA_W'(prod >>> FRAC_W) + s0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (sample_tick) state_n = ADDR0;
      ADDR0:   state_n = CAP0;
`ifdef WAVETABLE_OSC_INTERP_EN
      CAP0:    state_n = CAP1;
      CAP1:    state_n = IDLE;
`else
      CAP0:    state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && sample_tick;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc             <= '0;
      phase_idx       <= '0;
      band            <= '0;
      waveform_select <= '0;
      sample          <= '0;
      sample_valid    <= 1'b0;
      overrun         <= 1'b0;
`ifdef WAVETABLE_OSC_INTERP_EN
      frac            <= '0;
      s0              <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && busy) overrun <= 1'b1;
      if (accept) begin
        waveform_select <= wave_sel;
        band            <= band_nx;
        phase_idx       <= base[PHASE_W-1 -: N_LUT];
        acc             <= base + phase_inc;
`ifdef WAVETABLE_OSC_INTERP_EN
        frac            <= base[PHASE_W-N_LUT-1 -: FRAC_W];
`endif
      end
`ifdef WAVETABLE_OSC_INTERP_EN
      if (state == ADDR0) phase_idx <= phase_idx + 1'b1;
      if (state == CAP0)  s0 <= lut_data;
      if (state == CAP1) begin
        sample       <= interp;
        sample_valid <= 1'b1;
      end
`else
      if (state == CAP0) begin
        sample       <= lut_data;
        sample_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wavetable_oscillator.sv
// Self-checking bench for wavetable_oscillator with a registered ROM
// model and a latency-based reference model of accepted ticks.
module tb_wavetable_oscillator;

`ifdef WAVETABLE_OSC_INTERP_EN
  localparam int LAT = 3;
  localparam bit INTERP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit INTERP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               sample_tick;
  logic               sync;
  logic [31:0]        phase_inc;
  logic [1:0]         wave_sel;
  logic [1:0]         waveform_select;
  logic [9:0]         phase_idx;
  logic [5:0]         band;
  logic signed [23:0] lut_data;
  logic signed [23:0] sample;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  wavetable_oscillator dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .sync(sync),
    .phase_inc(phase_inc), .wave_sel(wave_sel),
    .waveform_select(waveform_select), .phase_idx(phase_idx),
    .band(band), .lut_data(lut_data), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Table content; entry value also depends on waveform and band
  int lut [1024];

  function automatic logic signed [23:0] rom(int w, int b, int i);
    return 24'(lut[i] + w * 65536 + b * 4096);
  endfunction

  always @(posedge clk)
    lut_data <= rom(int'(waveform_select), int'(band), int'(phase_idx));

  function automatic longint floordiv256(longint d);
    if (d >= 0) return d / 256;
    return -((-d + 255) / 256);
  endfunction

  // Reference model: what each accepted tick must produce, and when.
  bit          m_ok = 1'b0;
  longint      cyc = 0;
  longint      due = -1;
  longint      busy_end = 0;
  longint      inc_at = -1;
  longint      pend = 0;
  longint      m_sample = 0;
  longint      m_acc = 0;
  longint      m_idx = 0;
  longint      m_band = 0;
  longint      m_wave = 0;
  bit          m_ovr = 1'b0;

  always @(posedge clk) begin
    longint b, fr, s0, s1;
    cyc++;
    if (!rst_n) begin
      m_ok = 1'b1;
      due = -1; busy_end = 0; inc_at = -1;
      m_sample = 0; m_acc = 0; m_idx = 0;
      m_band = 0; m_wave = 0; m_ovr = 1'b0;
    end else begin
      if (cyc == due) m_sample = pend;
      if (cyc == inc_at) m_idx = (m_idx + 1) % 1024;
      if (sample_tick) begin
        if (cyc > busy_end) begin
          b      = sync ? 0 : m_acc;
          m_idx  = b / (64'd1 << 22);
          fr     = (b / (64'd1 << 14)) % 256;
          m_acc  = (b + longint'(phase_inc)) % (64'd1 << 32);
          m_band = longint'(phase_inc) / (64'd1 << 26);
          if (m_band > 21) m_band = 21;
          m_wave = wave_sel;
          s0 = rom(int'(m_wave), int'(m_band), int'(m_idx));
          if (INTERP) begin
            s1 = rom(int'(m_wave), int'(m_band), int'((m_idx + 1) % 1024));
            pend = s0 + floordiv256((s1 - s0) * fr);
            inc_at = cyc + 1;
          end else begin
            pend = s0;
          end
          due = cyc + LAT;
          busy_end = cyc + LAT;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  end

  int vcnt = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy", busy, longint'(cyc < busy_end));
      chk("sample_valid", sample_valid, longint'(cyc == due));
      chk("sample", sample, m_sample);
      chk("overrun", overrun, m_ovr);
      chk("phase_idx", phase_idx, m_idx);
      chk("band", band, m_band);
      chk("waveform_select", waveform_select, m_wave);
    end
    if (sample_valid === 1'b1) vcnt++;
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(logic [31:0] inc, logic [1:0] w, logic s);
    sample_tick = 1'b1;
    phase_inc   = inc;
    wave_sel    = w;
    sync        = s;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    sync        = 1'b0;
  endtask

  logic [31:0] incs [6];
  logic [1:0]  wvs  [6];
  int          v0;

  initial begin
    for (int i = 0; i < 1024; i++) lut[i] = i * 997 - 400000;
    incs[0] = 32'h0100_0000; wvs[0] = 2'd0;
    incs[1] = 32'h0C00_0000; wvs[1] = 2'd1;
    incs[2] = 32'h7FFF_FFFF; wvs[2] = 2'd2;
    incs[3] = 32'h0003_3333; wvs[3] = 2'd3;
    incs[4] = 32'h5400_0000; wvs[4] = 2'd1;
    incs[5] = 32'hFFFF_FFFF; wvs[5] = 2'd0;

    rst_n = 1'b0; sample_tick = 1'b0; sync = 1'b0;
    phase_inc = '0; wave_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idx", phase_idx, 0);
    chk("rst_band", band, 0);
    chk("rst_wave", waveform_select, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 4; n++) begin
      tick(32'h0100_0000, 2'd0, 1'b0);
      chk("basic_idx", phase_idx, n * 4);
      chk("basic_band", band, 0);
      idle(7);
    end

    tick(32'h0400_0000, 2'd2, 1'b0);
    chk("band_one", band, 1);
    chk("band_wave", waveform_select, 2);
    idle(7);
    tick(32'hFFFF_FFFF, 2'd3, 1'b0);
    chk("band_clamp", band, 21);
    idle(7);

    lut[1023] = 1000;
    lut[0]    = 2000;
    tick(32'hFFE0_0000, 2'd0, 1'b1);
    chk("sync_idx", phase_idx, 0);
    idle(7);
    tick(32'h0000_1000, 2'd0, 1'b0);
    chk("sync_acc_idx", phase_idx, 1023);
    idle(1);
    if (INTERP) begin
      chk("wrap_idx", phase_idx, 0);
      chk("wrap_band", band, 0);
    end
    idle(6);
    chk("wrap_sample", sample, INTERP ? 1500 : 1000);

    lut[5] = 100;
    lut[6] = -100;
    tick(32'h0140_4000, 2'd0, 1'b1);
    idle(7);
    tick(32'h0000_0100, 2'd0, 1'b0);
    chk("sign_idx", phase_idx, 5);
    idle(7);
    chk("sign_sample", sample, INTERP ? 99 : 100);

    chk("ovr_before", overrun, 0);
    v0 = vcnt;
    sample_tick = 1'b1;
    phase_inc = 32'h0123_4567;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    idle(8);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valids", vcnt - v0, 1);

    v0 = vcnt;
    tick(32'h0200_0000, 2'd1, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(6);
    chk("midrst_valids", vcnt - v0, 0);

    v0 = vcnt;
    for (int i = 0; i < 6; i++) begin
      tick(incs[i], wvs[i], 1'b0);
      idle(LAT);
    end
    idle(8);
    chk("b2b_valids", vcnt - v0, 6);
    chk("b2b_ovr", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
